// File: rtl/cond_pkg.sv
// Shared types and helpers for the condition/flag unit.
// Latency: n/a (declarations and a pure combinational helper only).
// Backpressure: n/a.
package cond_pkg;

    // Instruction condition field encodings
    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_t;

    // Bit positions inside the {N,Z,C,V} flags word
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // ALU operation codes; only arithmetic ops produce meaningful C/V
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    // Evaluate a condition code against a flags word
    function automatic logic cond_pass(input cond_t c, input logic [3:0] f);
        logic n, z, cy, v;
        n  = f[FLAG_N];
        z  = f[FLAG_Z];
        cy = f[FLAG_C];
        v  = f[FLAG_V];
        case (c)
            COND_EQ: cond_pass = z;
            COND_NE: cond_pass = !z;
            COND_CS: cond_pass = cy;
            COND_CC: cond_pass = !cy;
            COND_MI: cond_pass = n;
            COND_PL: cond_pass = !n;
            COND_VS: cond_pass = v;
            COND_VC: cond_pass = !v;
            COND_HI: cond_pass = cy && !z;
            COND_LS: cond_pass = !cy || z;
            COND_GE: cond_pass = (n == v);
            COND_LT: cond_pass = (n != v);
            COND_GT: cond_pass = !z && (n == v);
            COND_LE: cond_pass = z || (n != v);
            COND_AL: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/flag_stack.sv
// LIFO of 4-bit NZCV entries used to save/restore flags across handler nesting.
// Latency: push/pop take effect at the next edge; rd_dat is the live top entry.
// Backpressure: none; illegal push/pop is dropped and flagged by a one-cycle err pulse.
module flag_stack #(
    parameter int STACK_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic [3:0] wr_dat,
    output logic [3:0] rd_dat,
    output logic       pop_ok,
    output logic       full,
    output logic       empty,
    output logic       err
);

    localparam int CNT_W = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [3:0]       mem [STACK_DEPTH];
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_m1;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic             push_ok;
    logic             err_nxt;

    assign full     = (count == CNT_W'(STACK_DEPTH));
    assign empty    = (count == '0);
    assign count_m1 = count - 1'b1;
    assign wr_idx   = count[IDX_W-1:0];
    assign rd_idx   = count_m1[IDX_W-1:0];
    assign rd_dat   = mem[rd_idx];

    // Accept a lone push/pop only when it fits; anything else is an error
    always_comb begin
        push_ok = push && !pop && !full;
        pop_ok  = pop && !push && !empty;
        err_nxt = (push && pop) || (push && full) || (pop && empty);
    end

    // Occupancy counter and error pulse; count stays within 0..STACK_DEPTH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            err   <= 1'b0;
        end else begin
            err <= err_nxt;
            if (push_ok)
                count <= count + 1'b1;
            else if (pop_ok)
                count <= count_m1;
        end
    end

    // Entry storage; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_idx] <= wr_dat;
    end

endmodule

// File: rtl/cond_flag_unit.sv
// Flags register, condition decode and control gating between decoder and datapath.
// Latency: cond_ex and gated controls are combinational; flag updates appear one cycle later.
// Backpressure: stall freezes all state and forces the gated controls low.
module cond_flag_unit
    import cond_pkg::*;
#(
    parameter int STACK_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       alu_negative,
    input  logic       alu_zero,
    input  logic       alu_carry,
    input  logic       alu_overflow,
    input  logic [1:0] alu_control,
    input  logic [3:0] cond,
    input  logic       flag_write,
    input  logic       reg_write_in,
    input  logic       mem_write_in,
    input  logic       pc_src_in,
    input  logic       stall,
    input  logic       push,
    input  logic       pop,
    output logic       cond_ex,
    output logic       reg_write,
    output logic       mem_write,
    output logic       pc_src,
    output logic [3:0] flags,
    output logic       stack_full,
    output logic       stack_empty,
    output logic       stack_err
);

    logic [3:0] flags_nxt;
    logic [3:0] stack_top;
    logic       stack_pop_ok;
    logic       flag_upd;
    logic       arith_op;

    // Condition check always uses the registered flags: no forwarding
    assign cond_ex = cond_pass(cond_t'(cond), flags);

    // Decoder controls pass only when the condition holds and the pipe is moving
    always_comb begin
        reg_write = reg_write_in && cond_ex && !stall;
        mem_write = mem_write_in && cond_ex && !stall;
        pc_src    = pc_src_in    && cond_ex && !stall;
    end

    assign flag_upd = flag_write && cond_ex && !stall && !pop;
    assign arith_op = (alu_control == ALU_ADD) || (alu_control == ALU_SUB);

    // Stack sees stall-masked requests so a stalled cycle raises no error.
    // It stores the pre-update flags; an update in the same cycle still lands.
    flag_stack #(
        .STACK_DEPTH (STACK_DEPTH)
    ) u_flag_stack (
        .clk    (clk),
        .reset  (reset),
        .push   (push && !stall),
        .pop    (pop && !stall),
        .wr_dat (flags),
        .rd_dat (stack_top),
        .pop_ok (stack_pop_ok),
        .full   (stack_full),
        .empty  (stack_empty),
        .err    (stack_err)
    );

    // Next flags: a successful pop wins, else N/Z always and C/V only for arithmetic ops
    always_comb begin
        flags_nxt = flags;
        if (stack_pop_ok) begin
            flags_nxt = stack_top;
        end else if (flag_upd) begin
            flags_nxt[FLAG_N] = alu_negative;
            flags_nxt[FLAG_Z] = alu_zero;
            if (arith_op) begin
                flags_nxt[FLAG_C] = alu_carry;
                flags_nxt[FLAG_V] = alu_overflow;
            end
        end
    end

    // Architectural flags register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            flags <= 4'b0000;
        else
            flags <= flags_nxt;
    end

endmodule

// File: tb/tb_cond_flag_unit.sv
module tb_cond_flag_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       alu_negative, alu_zero, alu_carry, alu_overflow;
    logic [1:0] alu_control;
    logic [3:0] cond;
    logic       flag_write;
    logic       reg_write_in, mem_write_in, pc_src_in;
    logic       stall, push, pop;
    logic       cond_ex, reg_write, mem_write, pc_src;
    logic [3:0] flags;
    logic       stack_full, stack_empty, stack_err;

    int checks   = 0;
    int failures = 0;

    // Hand-derived pass masks: bit f set when flags value f passes the code
    logic [15:0] pass_mask [16] = '{
        16'hF0F0, 16'h0F0F, 16'hCCCC, 16'h3333,
        16'hFF00, 16'h00FF, 16'hAAAA, 16'h5555,
        16'h0C0C, 16'hF3F3, 16'hAA55, 16'h55AA,
        16'h0A05, 16'hF5FA, 16'hFFFF, 16'h0000
    };
    logic [3:0] push_vals [4] = '{4'h3, 4'h5, 4'h9, 4'hC};

    cond_flag_unit #(.STACK_DEPTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .alu_negative (alu_negative),
        .alu_zero     (alu_zero),
        .alu_carry    (alu_carry),
        .alu_overflow (alu_overflow),
        .alu_control  (alu_control),
        .cond         (cond),
        .flag_write   (flag_write),
        .reg_write_in (reg_write_in),
        .mem_write_in (mem_write_in),
        .pc_src_in    (pc_src_in),
        .stall        (stall),
        .push         (push),
        .pop          (pop),
        .cond_ex      (cond_ex),
        .reg_write    (reg_write),
        .mem_write    (mem_write),
        .pc_src       (pc_src),
        .flags        (flags),
        .stack_full   (stack_full),
        .stack_empty  (stack_empty),
        .stack_err    (stack_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_alu(input logic [3:0] v, input logic [1:0] op);
        {alu_negative, alu_zero, alu_carry, alu_overflow} = v;
        alu_control = op;
    endtask

    // Load all four flags through an unconditional ADD
    task automatic load_flags(input logic [3:0] v);
        set_alu(v, 2'b00);
        cond       = 4'hE;
        flag_write = 1'b1;
        tick();
        flag_write = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        set_alu(4'h0, 2'b00);
        cond = 4'hE; flag_write = 0;
        reg_write_in = 1; mem_write_in = 0; pc_src_in = 0;
        stall = 0; push = 0; pop = 0;
        #2;
        chk("rst_flags", flags, 4'h0);
        chk("rst_empty", stack_empty, 1);
        chk("rst_full", stack_full, 0);
        chk("rst_err", stack_err, 0);
        chk("rst_cond_ex", cond_ex, 1);
        chk("rst_reg_write", reg_write, 1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        reg_write_in = 0;

        // 1: ADD sets 0110; old flags seen in the same cycle
        set_alu(4'b0110, 2'b00);
        flag_write = 1;
        #1;
        chk("same_cycle_old_flags", flags, 4'h0);
        tick();
        flag_write = 0;
        chk("add_flags", flags, 4'b0110);
        cond = 4'h0; #1;
        chk("eq_pass", cond_ex, 1);
        cond = 4'h1; reg_write_in = 1; mem_write_in = 1; pc_src_in = 1; #1;
        chk("ne_fail", cond_ex, 0);
        chk("ne_reg_write", reg_write, 0);
        chk("ne_pc_src", pc_src, 0);
        cond = 4'h0; #1;
        chk("eq_mem_write", mem_write, 1);
        reg_write_in = 0; mem_write_in = 0; pc_src_in = 0;

        // 2: logic ops keep C and V
        cond = 4'hE; set_alu(4'b1000, 2'b10); flag_write = 1;
        tick();
        chk("and_flags", flags, 4'b1010);
        set_alu(4'b0101, 2'b11);
        tick();
        flag_write = 0;
        chk("or_flags", flags, 4'b0110);
        // SUB loads C/V
        set_alu(4'b0001, 2'b01); flag_write = 1;
        tick();
        flag_write = 0;
        chk("sub_flags", flags, 4'b0001);
        // Failed condition blocks the update
        cond = 4'h0; set_alu(4'b1111, 2'b00); flag_write = 1;
        tick();
        flag_write = 0;
        chk("cond_fail_no_upd", flags, 4'b0001);

        for (int f = 0; f < 16; f++) begin
            load_flags(4'(f));
            for (int c = 0; c < 16; c++) begin
                logic [15:0] m;
                cond = 4'(c);
                #1;
                m = pass_mask[c];
                chk($sformatf("sweep_c%0h_f%0h", c, f), cond_ex, m[f]);
            end
        end
        cond = 4'hE;

        // 3: fill, overflow, drain, underflow
        for (int i = 0; i < 4; i++) begin
            load_flags(push_vals[i]);
            push = 1;
            tick();
            push = 0;
            chk($sformatf("push%0d_err", i), stack_err, 0);
        end
        chk("full_after_4", stack_full, 1);
        chk("not_empty_after_4", stack_empty, 0);
        push = 1;
        tick();
        push = 0;
        chk("overflow_err", stack_err, 1);
        tick();
        chk("overflow_err_pulse", stack_err, 0);
        chk("still_full", stack_full, 1);
        load_flags(4'hF);
        for (int i = 3; i >= 0; i--) begin
            pop = 1;
            tick();
            pop = 0;
            chk($sformatf("pop%0d_flags", i), flags, push_vals[i]);
        end
        chk("empty_after_pops", stack_empty, 1);
        pop = 1;
        tick();
        pop = 0;
        chk("underflow_err", stack_err, 1);
        chk("underflow_flags", flags, 4'h3);
        tick();
        chk("underflow_err_pulse", stack_err, 0);

        // 4: push with update, pop overrides update
        load_flags(4'b0110);
        set_alu(4'b1001, 2'b00); flag_write = 1; push = 1;
        tick();
        push = 0;
        chk("push_upd_flags", flags, 4'b1001);
        chk("push_upd_not_empty", stack_empty, 0);
        set_alu(4'b1111, 2'b00); pop = 1;
        tick();
        pop = 0; flag_write = 0;
        chk("pop_over_upd", flags, 4'b0110);
        chk("pop_upd_empty", stack_empty, 1);
        push = 1; pop = 1;
        tick();
        push = 0; pop = 0;
        chk("push_pop_err", stack_err, 1);
        chk("push_pop_empty", stack_empty, 1);

        // 5: stall freezes everything
        load_flags(4'h6);
        push = 1; tick(); push = 0;
        load_flags(4'h3);
        push = 1; tick(); push = 0;
        stall = 1; flag_write = 1; push = 1; set_alu(4'hF, 2'b00);
        reg_write_in = 1; mem_write_in = 1; pc_src_in = 1;
        #1;
        chk("stall_reg_write", reg_write, 0);
        chk("stall_mem_write", mem_write, 0);
        chk("stall_pc_src", pc_src, 0);
        tick();
        chk("stall_flags", flags, 4'h3);
        chk("stall_err", stack_err, 0);
        pop = 1;
        tick();
        chk("stall_pop_err", stack_err, 0);
        stall = 0; flag_write = 0; push = 0; pop = 0;
        reg_write_in = 0; mem_write_in = 0; pc_src_in = 0;
        // Two more pushes fill the stack only if count was still 2
        push = 1; tick(); chk("stall_cnt_3_not_full", stack_full, 0);
        tick(); push = 0;
        chk("stall_cnt_full", stack_full, 1);
        pop = 1; tick(); tick(); pop = 0;
        chk("back_to_two_flags", flags, 4'h3);
        load_flags(4'hA);
        #1;
        reset = 1;
        #1;
        chk("mid_rst_flags", flags, 4'h0);
        chk("mid_rst_empty", stack_empty, 1);
        chk("mid_rst_full", stack_full, 0);
        @(negedge clk);
        reset = 0;
        tick();
        chk("post_rst_err", stack_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
